// File: rtl/peak_pair_hasher.sv
// Pairs each new frame's peaks (targets) with peaks of the previous ZONE frames (anchors)
// and streams {f_anchor, f_target, dt} hashes. Optional amplitude gate: PEAK_AMPL_FILTER_EN.
`ifndef FREQ_WIDTH
`define FREQ_WIDTH 9
`endif
`ifndef FINAL_AMPL_WIDTH
`define FINAL_AMPL_WIDTH 16
`endif
`ifndef TIME_COUNTER_WIDTH
`define TIME_COUNTER_WIDTH 16
`endif
`ifndef PEAKS
`define PEAKS 6
`endif

module peak_pair_hasher #(
    parameter int FREQ_WIDTH = `FREQ_WIDTH,
    parameter int AMPL_WIDTH = `FINAL_AMPL_WIDTH,
    parameter int TIME_WIDTH = `TIME_COUNTER_WIDTH,
    parameter int PEAKS      = `PEAKS,
    parameter int ZONE       = 2,
    parameter int DT_WIDTH   = 2,
    parameter int MIN_AMPL   = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  valid_in,
    input  logic [PEAKS-1:0][AMPL_WIDTH-1:0]      amplitudes_in,
    input  logic [PEAKS-1:0][FREQ_WIDTH-1:0]      freqs_in,
    input  logic [TIME_WIDTH-1:0]                 counter_in,
    input  logic                                  ready_in,
    output logic                                  valid_out,
    output logic [2*FREQ_WIDTH+DT_WIDTH-1:0]      hash_out,
    output logic [TIME_WIDTH-1:0]                 anchor_time_out,
    output logic                                  busy_out,
    output logic                                  frame_done_out,
    output logic                                  drop_out
);
    localparam int SW = $clog2(ZONE + 1);
    localparam int PW = (PEAKS > 1) ? $clog2(PEAKS) : 1;
    localparam int HW = 2 * FREQ_WIDTH + DT_WIDTH;
    localparam logic signed [AMPL_WIDTH-1:0] MIN_A = AMPL_WIDTH'(MIN_AMPL);

    // PREP gives the freshly written slot a cycle before the first candidate is evaluated.
    typedef enum logic [2:0] {IDLE, PREP, SCAN, EMIT, DONE} state_t;

    state_t                                   state_q;
    logic [ZONE:0][PEAKS-1:0][FREQ_WIDTH-1:0] freq_q;
    logic [ZONE:0][TIME_WIDTH-1:0]            time_q;
    logic [SW-1:0]                            wp_q, cur_q;
    logic [DT_WIDTH-1:0]                      stored_q, avail_q, lag_q, lag_d;
    logic [PW-1:0]                            a_q, a_d, t_q, t_d;
    logic                                     last_q;
    logic                                     valid_q, busy_q, done_q, drop_q;
    logic [HW-1:0]                            hash_q;
    logic [TIME_WIDTH-1:0]                    atime_q;

    logic [SW-1:0] anc_slot_c;
    logic          last_c, accept_c;
    logic [HW-1:0] hash_c;

    always_comb begin
        anc_slot_c = (SW'(lag_q) > cur_q) ? cur_q + SW'(ZONE + 1) - SW'(lag_q)
                                          : cur_q - SW'(lag_q);
        last_c = (lag_q == avail_q) && (a_q == PW'(PEAKS - 1)) && (t_q == PW'(PEAKS - 1));
        hash_c = {freq_q[anc_slot_c][a_q], freq_q[cur_q][t_q], lag_q};
        t_d    = t_q + PW'(1);
        a_d    = a_q;
        lag_d  = lag_q;
        if (t_q == PW'(PEAKS - 1)) begin
            t_d = '0;
            a_d = a_q + PW'(1);
            if (a_q == PW'(PEAKS - 1)) begin
                a_d   = '0;
                lag_d = lag_q + DT_WIDTH'(1);
            end
        end
    end

`ifdef PEAK_AMPL_FILTER_EN
    logic [ZONE:0][PEAKS-1:0][AMPL_WIDTH-1:0] ampl_q;

    assign accept_c = ($signed(ampl_q[anc_slot_c][a_q]) >= MIN_A) &&
                      ($signed(ampl_q[cur_q][t_q]) >= MIN_A);

    always_ff @(posedge clk) begin
        if (!reset && state_q == IDLE && valid_in)
            ampl_q[wp_q] <= amplitudes_in;
    end
`else
    logic unused_ampl;
    assign unused_ampl = ^{amplitudes_in, MIN_A};
    assign accept_c    = 1'b1;
`endif

    // Slot contents need no reset: stored_q == 0 keeps stale slots out of any scan.
    always_ff @(posedge clk) begin
        if (!reset && state_q == IDLE && valid_in) begin
            freq_q[wp_q] <= freqs_in;
            time_q[wp_q] <= counter_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wp_q     <= '0;
            cur_q    <= '0;
            stored_q <= '0;
            avail_q  <= '0;
            lag_q    <= '0;
            a_q      <= '0;
            t_q      <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            hash_q   <= '0;
            atime_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= valid_in && (state_q != IDLE);
            case (state_q)
                IDLE: if (valid_in) begin
                    cur_q    <= wp_q;
                    avail_q  <= stored_q;
                    wp_q     <= (wp_q == SW'(ZONE)) ? '0 : wp_q + SW'(1);
                    stored_q <= (stored_q == DT_WIDTH'(ZONE)) ? stored_q : stored_q + DT_WIDTH'(1);
                    lag_q    <= DT_WIDTH'(1);
                    a_q      <= '0;
                    t_q      <= '0;
                    busy_q   <= 1'b1;
                    state_q  <= PREP;
                end
                PREP: begin
                    if (avail_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    lag_q  <= lag_d;
                    a_q    <= a_d;
                    t_q    <= t_d;
                    last_q <= last_c;
                    if (accept_c) begin
                        valid_q <= 1'b1;
                        hash_q  <= hash_c;
                        atime_q <= time_q[anc_slot_c];
                        state_q <= EMIT;
                    end else if (last_c) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                EMIT: if (ready_in) begin
                    valid_q <= 1'b0;
                    if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_out       = valid_q;
    assign hash_out        = hash_q;
    assign anchor_time_out = atime_q;
    assign busy_out        = busy_q;
    assign frame_done_out  = done_q;
    assign drop_out        = drop_q;
endmodule

// File: tb/tb_peak_pair_hasher.sv
// Directed bench for peak_pair_hasher: frame capture, pairing order, stalls, drops, reset.
module tb_peak_pair_hasher;
    localparam int P    = 6;
    localparam int FW   = 9;
    localparam int AW   = 16;
    localparam int TW   = 16;
    localparam int ZN   = 2;
    localparam int DTW  = 2;
    localparam int HW   = 2 * FW + DTW;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   valid_in = 1'b0;
    logic [P-1:0][AW-1:0]   amplitudes_in = '0;
    logic [P-1:0][FW-1:0]   freqs_in = '0;
    logic [TW-1:0]          counter_in = '0;
    logic                   ready_in = 1'b1;
    logic                   valid_out;
    logic [HW-1:0]          hash_out;
    logic [TW-1:0]          anchor_time_out;
    logic                   busy_out, frame_done_out, drop_out;

    peak_pair_hasher #(
        .FREQ_WIDTH(FW), .AMPL_WIDTH(AW), .TIME_WIDTH(TW), .PEAKS(P),
        .ZONE(ZN), .DT_WIDTH(DTW), .MIN_AMPL(1)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .amplitudes_in(amplitudes_in),
        .freqs_in(freqs_in), .counter_in(counter_in), .ready_in(ready_in),
        .valid_out(valid_out), .hash_out(hash_out), .anchor_time_out(anchor_time_out),
        .busy_out(busy_out), .frame_done_out(frame_done_out), .drop_out(drop_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int cap = 0;
    logic [HW+TW-1:0] q[$];
    logic [P-1:0][AW-1:0] amps_pos, amps_flt;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(posedge clk) if (valid_out && ready_in) q.push_back({hash_out, anchor_time_out});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [HW+TW-1:0] qget(input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    // freqs of frame k are 6k+1 .. 6k+6
    task automatic send(input int k, input int tcnt, input logic [P-1:0][AW-1:0] amps);
        for (int p = 0; p < P; p++) freqs_in[p] = FW'(6 * k + p + 1);
        counter_in    = TW'(tcnt);
        amplitudes_in = amps;
        valid_in      = 1'b1;
        step();
        valid_in = 1'b0;
        cap      = cyc_cnt;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_out && n < 1000) begin
            step();
            n++;
        end
        chk("idle_timeout", {63'd0, busy_out}, 64'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_out && n < 100) begin
            step();
            n++;
        end
        chk("valid_timeout", {63'd0, valid_out}, 64'd1);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_valid"}, {63'd0, valid_out}, 64'd0);
        chk({tag, "_hash"}, {44'd0, hash_out}, 64'd0);
        chk({tag, "_atime"}, {48'd0, anchor_time_out}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy_out}, 64'd0);
        chk({tag, "_done"}, {63'd0, frame_done_out}, 64'd0);
        chk({tag, "_drop"}, {63'd0, drop_out}, 64'd0);
    endtask

    // Frame k (time 100*(k+1)) paired against up to ZN earlier frames, lag outermost.
    task automatic check_frame(input string tag, input int k, input int base);
        int av = (k < ZN) ? k : ZN;
        int idx = base;
        logic [HW+TW-1:0] e;
        chk({tag, "_count"}, 64'(q.size() - base), 64'(av * P * P));
        for (int l = 1; l <= av; l++)
            for (int a = 0; a < P; a++)
                for (int t = 0; t < P; t++) begin
                    e = {FW'(6 * (k - l) + a + 1), FW'(6 * k + t + 1), DTW'(l), TW'(100 * (k - l + 1))};
                    chk({tag, "_hash"}, 64'(qget(idx)), 64'(e));
                    idx++;
                end
    endtask

    initial begin
        int base;
        for (int p = 0; p < P; p++) amps_pos[p] = AW'(10);
        amps_flt[0] = AW'(5);  amps_flt[1] = AW'(0); amps_flt[2] = -AW'(8);
        amps_flt[3] = AW'(1);  amps_flt[4] = AW'(0); amps_flt[5] = AW'(0);

        step(); step(); step();
        chk_zero_outs("rst");
        reset = 1'b0;
        step();

        // Frame 1: nothing to pair against
        base = q.size();
        send(0, 100, amps_pos);
        chk("f1_valid_n", {63'd0, valid_out}, 64'd0);
        chk("f1_done_n", {63'd0, frame_done_out}, 64'd0);
        step();
        chk("f1_done_n1", {63'd0, frame_done_out}, 64'd1);
        chk("f1_busy_n1", {63'd0, busy_out}, 64'd1);
        step();
        chk("f1_busy_n2", {63'd0, busy_out}, 64'd0);
        chk("f1_done_n2", {63'd0, frame_done_out}, 64'd0);
        chk("f1_cycles", 64'(cyc_cnt - cap), 64'd2);
        chk("f1_hashes", 64'(q.size() - base), 64'd0);

        // Frame 2: 36 hashes against frame 1, back-to-back
        base = q.size();
        send(1, 200, amps_pos);
        chk("f2_valid_n", {63'd0, valid_out}, 64'd0);
        step();
        chk("f2_valid_n1", {63'd0, valid_out}, 64'd0);
        step();
        chk("f2_valid_n2", {63'd0, valid_out}, 64'd1);
        chk("f2_first_live", {44'd0, hash_out}, {44'd0, 9'd1, 9'd7, 2'd1});
        wait_idle();
        chk("f2_cycles", 64'(cyc_cnt - cap), 64'd74);
        chk("f2_first", 64'(qget(base)), {28'd0, 9'd1, 9'd7, 2'd1, 16'd100});
        chk("f2_last", 64'(qget(base + 35)), {28'd0, 9'd6, 9'd12, 2'd1, 16'd100});
        check_frame("f2", 1, base);

        // Frame 3: 72 hashes, with an ignored valid_in mid-scan
        base = q.size();
        send(2, 300, amps_pos);
        repeat (5) step();
        for (int p = 0; p < P; p++) freqs_in[p] = 9'h1FF;
        counter_in = 16'hDEAD;
        valid_in   = 1'b1;
        step();
        valid_in = 1'b0;
        chk("drop_pulse", {63'd0, drop_out}, 64'd1);
        step();
        chk("drop_clear", {63'd0, drop_out}, 64'd0);
        wait_idle();
        chk("f3_cycles", 64'(cyc_cnt - cap), 64'd146);
        chk("f3_l2_first", 64'(qget(base + 36)), {28'd0, 9'd1, 9'd13, 2'd2, 16'd100});
        check_frame("f3", 2, base);

        // Frame 4: wraps to slot 0, first hash stalled for 5 cycles
        base = q.size();
        ready_in = 1'b0;
        send(3, 400, amps_pos);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {63'd0, valid_out}, 64'd1);
            chk("stall_hash", {44'd0, hash_out}, {44'd0, 9'd13, 9'd19, 2'd1});
            chk("stall_atime", {48'd0, anchor_time_out}, 64'd300);
            step();
        end
        ready_in = 1'b1;
        wait_idle();
        check_frame("f4", 3, base);

        // Frame 5: reset while a hash is held
        ready_in = 1'b0;
        send(4, 500, amps_pos);
        wait_valid();
        base  = q.size();
        reset = 1'b1;
        step();
        chk_zero_outs("midrst");
        reset    = 1'b0;
        ready_in = 1'b1;
        step();
        chk("midrst_hashes", 64'(q.size() - base), 64'd0);

        // Frame 6: buffer forgotten after reset
        send(0, 600, amps_pos);
        wait_idle();
        chk("f6_cycles", 64'(cyc_cnt - cap), 64'd2);
        chk("f6_hashes", 64'(q.size() - base), 64'd0);

        // Frame 7: amplitudes {5,0,-8,1,0,0} against all-positive frame 6
        base = q.size();
        send(1, 700, amps_flt);
        wait_idle();
`ifdef PEAK_AMPL_FILTER_EN
        chk("f7_count", 64'(q.size() - base), 64'd12);
        chk("f7_cycles", 64'(cyc_cnt - cap), 64'd50);
        for (int a = 0; a < P; a++)
            for (int j = 0; j < 2; j++)
                chk("f7_hash", 64'(qget(base + 2 * a + j)),
                    64'({FW'(a + 1), FW'(7 + 3 * j), 2'd1, 16'd600}));
`else
        chk("f7_count", 64'(q.size() - base), 64'd36);
        chk("f7_cycles", 64'(cyc_cnt - cap), 64'd74);
        for (int a = 0; a < P; a++)
            for (int t = 0; t < P; t++)
                chk("f7_hash", 64'(qget(base + P * a + t)),
                    64'({FW'(a + 1), FW'(7 + t), 2'd1, 16'd600}));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
